// File: rtl/etapa1.sv
// etapa1: first pipeline stage. Collects one frame of DEPTH samples from an
// upstream valid/ready stream into a BRAM through port A, then hands the
// frame to etapa2 and waits for etapa2 to finish reading before refilling.
module etapa1 #(
    parameter int DATA_W = 17,
    parameter int DEPTH  = 144,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              busy,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              data_done,
    output logic              frame_err,
    output logic [15:0]       frame_cnt
);

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        DONE      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_FREE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wrPtr_q, wrPtr_d;
    logic                wea_q, wea_d;
    logic [ADDR_W-1:0]   addra_q, addra_d;
    logic [DATA_W-1:0]   dina_q, dina_d;
    logic                dataDone_q, dataDone_d;
    logic                frameErr_q, frameErr_d;
    logic [15:0]         frameCnt_q, frameCnt_d;
    logic                missingLast_q, missingLast_d;
    logic                started_q;
    logic                accept;

    // started_q keeps in_ready low until the first clock edge after reset,
    // so the stream never sees a ready that no edge has yet qualified
    assign in_ready = started_q && (state_q == FILL);
    assign accept   = in_valid && in_ready;

    assign wea       = wea_q;
    assign addra     = addra_q;
    assign dina      = dina_q;
    assign data_done = dataDone_q;
    assign frame_err = frameErr_q;
    assign frame_cnt = frameCnt_q;

    // Next-state logic: fill the BRAM, announce the frame, then hand-shake
    // with etapa2 via busy (rise = ack, fall = BRAM free again)
    always_comb begin
        state_d       = state_q;
        wrPtr_d       = wrPtr_q;
        wea_d         = 1'b0;
        addra_d       = addra_q;
        dina_d        = dina_q;
        dataDone_d    = 1'b0;
        frameErr_d    = 1'b0;
        frameCnt_d    = frameCnt_q;
        missingLast_d = missingLast_q;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    wea_d   = 1'b1;
                    addra_d = wrPtr_q;
                    dina_d  = in_data;
                    if (wrPtr_q == LAST_IDX) begin
                        state_d       = DONE;
                        wrPtr_d       = '0;
                        missingLast_d = !in_last;
                    end else if (in_last) begin
                        frameErr_d = 1'b1;
                        wrPtr_d    = '0;
                    end else begin
                        wrPtr_d = wrPtr_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d       = WAIT_ACK;
                dataDone_d    = 1'b1;
                frameErr_d    = missingLast_q;
                missingLast_d = 1'b0;
                frameCnt_d    = frameCnt_q + 16'd1;
            end
            WAIT_ACK: begin
                if (busy) begin
                    state_d = WAIT_FREE;
                end
            end
            WAIT_FREE: begin
                if (!busy) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State and output registers; reset drops any partial frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= FILL;
            wrPtr_q       <= '0;
            wea_q         <= 1'b0;
            addra_q       <= '0;
            dina_q        <= '0;
            dataDone_q    <= 1'b0;
            frameErr_q    <= 1'b0;
            frameCnt_q    <= '0;
            missingLast_q <= 1'b0;
            started_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wrPtr_q       <= wrPtr_d;
            wea_q         <= wea_d;
            addra_q       <= addra_d;
            dina_q        <= dina_d;
            dataDone_q    <= dataDone_d;
            frameErr_q    <= frameErr_d;
            frameCnt_q    <= frameCnt_d;
            missingLast_q <= missingLast_d;
            started_q     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_etapa1.sv
// tb_etapa1: randomized bench for etapa1 with a cycle-level reference model
// built from frame-level bookkeeping (sample index, completion cycle, busy
// hand-shake progress).
module tb_etapa1;

    localparam int DATA_W = 17;
    localparam int DEPTH  = 144;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic              busy = 1'b0;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic              data_done;
    logic              frame_err;
    logic [15:0]       frame_cnt;

    etapa1 #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .busy(busy),
        .wea(wea), .addra(addra), .dina(dina),
        .data_done(data_done), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    // expected outputs for the current cycle
    logic              expReady, expWea, expDone, expErr;
    logic [ADDR_W-1:0] expAddra;
    logic [DATA_W-1:0] expDina;
    logic [15:0]       expCnt;

    // frame-level bookkeeping
    int sampleIdx = 0;
    bit blocked = 0;
    bit sawHigh = 0;
    int doneCycle = -1;
    bit errAtDone = 0;
    int modelDoneCount = 0;
    int obsDoneCount = 0;

    // stimulus knobs
    int validPct = 100;
    bit toggleValid = 0;
    bit toggleState = 0;
    bit dataIsIndex = 1;
    int lastMode = 0;
    int earlyIdx = 50;
    bit earlyPending = 0;
    int busyMode = 0;

    // Compare one observed value against the model's value
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic checkAll();
        checkOutput("in_ready", in_ready, expReady);
        checkOutput("wea", wea, expWea);
        checkOutput("addra", addra, expAddra);
        checkOutput("dina", dina, expDina);
        checkOutput("data_done", data_done, expDone);
        checkOutput("frame_err", frame_err, expErr);
        checkOutput("frame_cnt", frame_cnt, expCnt);
    endtask

    task automatic clearModel();
        expReady = 1'b0; expWea = 1'b0; expDone = 1'b0; expErr = 1'b0;
        expAddra = '0; expDina = '0; expCnt = '0;
        sampleIdx = 0; blocked = 0; sawHigh = 0; doneCycle = -1; errAtDone = 0;
    endtask

    // Asynchronous reset applied mid-cycle, checked before any clock edge
    task automatic applyReset();
        reset = 1'b0;
        in_valid = 1'b0;
        busy = 1'b0;
        #1;
        clearModel();
        checkAll();
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("in_ready_before_edge", in_ready, 1'b0);
        @(posedge clk);
        #1;
        cyc++;
        expReady = 1'b1;
    endtask

    // Choose this cycle's inputs from the active knobs
    task automatic applyStimulus();
        if (toggleValid) begin
            in_valid = toggleState;
            toggleState = !toggleState;
        end else begin
            in_valid = ($urandom_range(99) < validPct);
        end
        in_data = dataIsIndex ? DATA_W'(sampleIdx) : DATA_W'($urandom);
        case (lastMode)
            0: in_last = (sampleIdx == DEPTH - 1);
            1: in_last = 1'b0;
            2: in_last = (earlyPending && sampleIdx == earlyIdx) || (sampleIdx == DEPTH - 1);
            default: in_last = ($urandom_range(199) == 0) || (sampleIdx == DEPTH - 1);
        endcase
        if (!in_valid) in_last = $urandom_range(1);
        case (busyMode)
            0: busy = $urandom_range(1);
            1: busy = 1'b0;
            2: busy = (cyc >= doneCycle + 1) && (cyc < doneCycle + 11);
            default: busy = 1'b1;
        endcase
    endtask

    // Predict next cycle's outputs from this cycle's inputs
    task automatic modelStep();
        logic acc;
        logic nextWea, nextDone, nextErr;
        logic [ADDR_W-1:0] nextAddra;
        logic [DATA_W-1:0] nextDina;
        acc = in_valid && expReady;
        nextWea = acc;
        nextAddra = acc ? ADDR_W'(sampleIdx) : expAddra;
        nextDina = acc ? in_data : expDina;
        nextDone = (cyc + 1 == doneCycle);
        nextErr = nextDone && errAtDone;
        if (blocked) begin
            if (sawHigh) begin
                if (!busy) begin
                    blocked = 0;
                    sawHigh = 0;
                end
            end else if (cyc >= doneCycle && busy) begin
                sawHigh = 1;
            end
        end
        if (acc) begin
            if (sampleIdx == DEPTH - 1) begin
                blocked = 1;
                doneCycle = cyc + 2;
                errAtDone = !in_last;
                sampleIdx = 0;
            end else if (in_last) begin
                nextErr = 1'b1;
                sampleIdx = 0;
                if (lastMode == 2 && earlyPending) earlyPending = 0;
            end else begin
                sampleIdx++;
            end
        end
        if (nextDone) modelDoneCount++;
        expWea = nextWea;
        expAddra = nextAddra;
        expDina = nextDina;
        expDone = nextDone;
        expErr = nextErr;
        expCnt = expCnt + (nextDone ? 16'd1 : 16'd0);
        expReady = !blocked;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            checkAll();
            if (data_done === 1'b1) obsDoneCount++;
            applyStimulus();
            modelStep();
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        $display("[TB] etapa1 bench start");
        applyReset();

        // back-to-back frame with indexed data, busy pulse after completion
        validPct = 100; dataIsIndex = 1; lastMode = 0; busyMode = 2;
        runCycles(200);
        checkOutput("frame_cnt_after_first", frame_cnt, 16'd1);

        // in_valid alternating every cycle
        toggleValid = 1;
        runCycles(320);
        toggleValid = 0;

        // in_last on sample 50, then a normal frame
        lastMode = 2; earlyPending = 1; busyMode = 0;
        runCycles(260);

        // no in_last on the final sample
        lastMode = 1; busyMode = 2;
        runCycles(200);

        // busy stays low long after data_done, then a single rise and fall
        lastMode = 0; busyMode = 1;
        runCycles(300);
        busyMode = 3;
        runCycles(2);
        busyMode = 1;
        runCycles(20);

        // reset after 70 samples, then a clean frame from address 0
        validPct = 100;
        runCycles(70);
        applyReset();
        checkOutput("frame_cnt_after_reset", frame_cnt, 16'd0);
        busyMode = 2;
        runCycles(200);

        // fully random traffic
        validPct = 60; dataIsIndex = 0; lastMode = 3; busyMode = 0;
        runCycles(2000);

        checkOutput("done_pulse_count", obsDoneCount, modelDoneCount);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/etapa1.md
ETAPA1 -- requirements
Module: etapa1

Interface
REQ-001 Parameter DATA_W, default 17, sample and BRAM word width.
REQ-002 Parameter DEPTH, default 144, samples per frame (BRAM entries written).
REQ-003 Parameter ADDR_W, default 8, BRAM address width; DEPTH <= 2**ADDR_W.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low; clears all state when 0.
REQ-006 in_valid  input  1  upstream sample valid.
REQ-007 in_data  input  DATA_W  upstream sample.
REQ-008 in_last  input  1  marks last sample of a frame.
REQ-009 in_ready  output  1  block accepts sample this cycle.
REQ-010 busy  input  1  downstream stage (etapa2) is reading the BRAM.
REQ-011 wea  output  1  BRAM port-A write enable.
REQ-012 addra  output  ADDR_W  BRAM port-A address.
REQ-013 dina  output  DATA_W  BRAM port-A write data.
REQ-014 data_done  output  1  one-cycle pulse: full frame is in BRAM.
REQ-015 frame_err  output  1  one-cycle pulse: in_last framing mismatch.
REQ-016 frame_cnt  output  16  count of completed frames.

Function
REQ-017 States SHALL be FILL, DONE, WAIT_ACK, WAIT_FREE; reset state FILL.
REQ-018 Handshake: sample accepted on a cycle with in_valid=1 and in_ready=1; in_ready SHALL be 1 only in FILL.
REQ-019 In FILL, in_ready SHALL not depend combinationally on in_valid.
REQ-020 Write pointer wr_ptr SHALL start at 0 per frame and increment by 1 per accepted sample.
REQ-021 Accept at cycle N SHALL produce wea=1, addra=wr_ptr, dina=in_data registered at cycle N+1; wea=0 otherwise (latency 1).
REQ-022 addra and dina SHALL hold their last values when wea=0.
REQ-023 Accept of sample index DEPTH-1 SHALL move FILL->DONE; in_ready=0 from the next cycle.
REQ-024 DONE lasts one cycle, coinciding with the final wea; data_done SHALL pulse for exactly one cycle the cycle after the final wea (2 cycles after last accept), with transition DONE->WAIT_ACK.
REQ-025 frame_cnt SHALL increment (mod 2**16, wrap to 0) in the same cycle data_done is 1.
REQ-026 WAIT_ACK: stay until busy=1 is sampled, then WAIT_FREE; busy=1 sampled coincident with data_done SHALL count.
REQ-027 WAIT_FREE: stay until busy=0 is sampled, then FILL with wr_ptr=0; in_ready=1 the cycle after busy=0 is sampled.
REQ-028 Early in_last (accepted with index < DEPTH-1): SHALL pulse frame_err next cycle, still write that sample, reset wr_ptr to 0, stay in FILL, no data_done, frame_cnt unchanged.
REQ-029 Missing in_last on index DEPTH-1: frame SHALL complete normally (REQ-023/024) and frame_err SHALL pulse coincident with data_done.
REQ-030 busy changes while in FILL SHALL be ignored.
REQ-031 in_data/in_last SHALL be ignored when not accepted.

Reset
REQ-032 reset=0 SHALL asynchronously force state=FILL, wr_ptr=0, wea=0, addra=0, dina=0, data_done=0, frame_err=0, frame_cnt=0.
REQ-033 in_ready SHALL be 0 while reset=0 and 1 from the first rising edge after reset deasserts.
REQ-034 Reset mid-frame or in WAIT_ACK/WAIT_FREE SHALL discard the partial frame with no data_done pulse.

Verification
REQ-035 144 back-to-back samples 0..143, in_last on 143, busy pulses high 3 cycles later for 10 cycles -> wea at addra 0..143 with dina=addra, one data_done 2 cycles after last accept, frame_cnt=1, in_ready=1 after busy falls.
REQ-036 in_valid toggled 1/0 every cycle for a frame -> 144 writes in order, no gaps in addra, single data_done.
REQ-037 in_last on sample 50 -> frame_err one cycle later, next sample written to addra 0, no data_done.
REQ-038 No in_last on sample 143 -> data_done and frame_err pulse same cycle, frame_cnt=1.
REQ-039 busy held 0 after data_done for 100 cycles -> in_ready stays 0, no writes; busy 1 then 0 -> in_ready returns to 1.
REQ-040 reset=0 asserted after 70 samples, released -> all outputs at reset values immediately, next frame starts at addra 0, frame_cnt=0.
